// File: rtl/exec_decode_unit_pkg.sv
// Shared opcode, funct and ALU-control encodings for the decode/execute slice.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package exec_decode_unit_pkg;

  // Main opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_MOVE  = 6'b010001;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU control codes; ALU_RTYPE as a main-decoder op means "look at funct"
  localparam logic [2:0] ALU_JR    = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_ADD   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_NOR   = 3'b111;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // Datapath control strobes produced by the main decoder
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       byte_op;
    logic       move;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/exec_decode_unit_alu.sv
// 32-bit ALU: and/or/xor/nor, wrapping add/sub, signed set-less-than; code 000 yields 0.
// Latency: combinational.
// Backpressure: none.
module exec_decode_unit_alu
  import exec_decode_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    alu_ctr,
  output logic [DW-1:0] result
);

  // Operation select; add/sub simply wrap, there is no overflow trap
  always_comb begin
    result = '0;
    case (alu_ctr)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      ALU_ADD: result = a + b;
      ALU_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_decode_unit_ctrl.sv
// Main control decode plus ALU-control decode (opcode/funct -> strobes, alu_ctr).
// Latency: combinational.
// Backpressure: none; a new opcode/funct may be presented every cycle.
module exec_decode_unit_ctrl
  import exec_decode_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic [2:0] alu_ctr,
  output logic       illegal
);

  logic op_illegal;
  logic fn_illegal;

  // Main decoder: opcode -> datapath strobes and ALU op class
  always_comb begin
    ctrl       = '0;
    op_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (opcode)
          OP_ADDI: ctrl.alu_op = ALU_ADD;
          OP_SUBI: ctrl.alu_op = ALU_SUB;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_SLT;
        endcase
      end
      OP_LW, OP_LB: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.byte_op   = (opcode == OP_LB);
        ctrl.alu_op    = ALU_ADD;
      end
      OP_SW, OP_SB: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.byte_op   = (opcode == OP_SB);
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_MOVE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.move      = 1'b1;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  // ALU-control decoder: non-R ops pass straight through, R-type decodes funct
  always_comb begin
    alu_ctr    = ctrl.alu_op;
    fn_illegal = 1'b0;
    if (ctrl.alu_op == ALU_RTYPE) begin
      case (funct)
        FN_ADD:  alu_ctr = ALU_ADD;
        FN_SUB:  alu_ctr = ALU_SUB;
        FN_AND:  alu_ctr = ALU_AND;
        FN_OR:   alu_ctr = ALU_OR;
        FN_SLT:  alu_ctr = ALU_SLT;
        FN_JR:   alu_ctr = ALU_JR;
        default: begin
          alu_ctr    = ALU_JR;
          fn_illegal = 1'b1;
        end
      endcase
    end
  end

  assign illegal = op_illegal | fn_illegal;

endmodule

// File: rtl/exec_decode_unit.sv
// Decode/execute slice: control decode, ALU-control decode and ALU, all results registered.
// Latency: 1 cycle from instr/operands to every output.
// Backpressure: none; accepts a new instruction every cycle.
module exec_decode_unit
  import exec_decode_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic [DW-1:0] imm_ext,
  output logic          reg_dst,
  output logic          branch,
  output logic          mem_read,
  output logic          mem_write,
  output logic          byte_op,
  output logic          alu_src,
  output logic          reg_write,
  output logic          jump,
  output logic          move,
  output logic [2:0]    alu_op,
  output logic [2:0]    alu_ctr,
  output logic [DW-1:0] alu_result,
  output logic          zero,
  output logic          branch_taken,
  output logic          jr,
  output logic          illegal
);

  ctrl_t         ctrl;
  logic [2:0]    ctr;
  logic          dec_illegal;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] res;

  // Register/shamt fields are consumed elsewhere in the core
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  exec_decode_unit_ctrl u_ctrl (
    .opcode  (instr[31:26]),
    .funct   (instr[5:0]),
    .ctrl    (ctrl),
    .alu_ctr (ctr),
    .illegal (dec_illegal)
  );

  assign alu_b = ctrl.alu_src ? imm_ext : src_b;

  exec_decode_unit_alu #(.DW(DW)) u_alu (
    .a       (src_a),
    .b       (alu_b),
    .alu_ctr (ctr),
    .result  (res)
  );

  ctrl_t         ctrl_d,         ctrl_q;
  logic [2:0]    alu_ctr_d,      alu_ctr_q;
  logic [DW-1:0] alu_result_d,   alu_result_q;
  logic          zero_d,         zero_q;
  logic          branch_taken_d, branch_taken_q;
  logic          jr_d,           jr_q;
  logic          illegal_d,      illegal_q;

  // Derived flags; branch outranks the jr marker, and jr suppresses the write
  always_comb begin
    zero_d           = (res == '0);
    jr_d             = (ctr == ALU_JR) && (res == '0) && !ctrl.branch;
    branch_taken_d   = ctrl.branch & (zero_d ^ (instr[31:26] == OP_BNE));
    ctrl_d           = ctrl;
    ctrl_d.reg_write = ctrl.reg_write & ~jr_d;
    alu_ctr_d        = ctr;
    alu_result_d     = res;
    illegal_d        = dec_illegal;
  end

  // Single output register stage, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q         <= '0;
      alu_ctr_q      <= '0;
      alu_result_q   <= '0;
      zero_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      jr_q           <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      ctrl_q         <= ctrl_d;
      alu_ctr_q      <= alu_ctr_d;
      alu_result_q   <= alu_result_d;
      zero_q         <= zero_d;
      branch_taken_q <= branch_taken_d;
      jr_q           <= jr_d;
      illegal_q      <= illegal_d;
    end
  end

  assign reg_dst      = ctrl_q.reg_dst;
  assign branch       = ctrl_q.branch;
  assign mem_read     = ctrl_q.mem_read;
  assign mem_write    = ctrl_q.mem_write;
  assign byte_op      = ctrl_q.byte_op;
  assign alu_src      = ctrl_q.alu_src;
  assign reg_write    = ctrl_q.reg_write;
  assign jump         = ctrl_q.jump;
  assign move         = ctrl_q.move;
  assign alu_op       = ctrl_q.alu_op;
  assign alu_ctr      = alu_ctr_q;
  assign alu_result   = alu_result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_taken_q;
  assign jr           = jr_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_exec_decode_unit.sv
// Bench for exec_decode_unit: directed instruction scenarios plus randomized back-to-back stream.
// Each instruction's registered outputs are compared one cycle later against a semantic reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_exec_decode_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] imm_ext = '0;
  logic        reg_dst, branch, mem_read, mem_write, byte_op, alu_src, reg_write;
  logic        jump, move, zero, branch_taken, jr, illegal;
  logic [2:0]  alu_op, alu_ctr;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  exec_decode_unit #(.DW(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr        (instr),
    .src_a        (src_a),
    .src_b        (src_b),
    .imm_ext      (imm_ext),
    .reg_dst      (reg_dst),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .byte_op      (byte_op),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .jump         (jump),
    .move         (move),
    .alu_op       (alu_op),
    .alu_ctr      (alu_ctr),
    .alu_result   (alu_result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .jr           (jr),
    .illegal      (illegal)
  );

  // All outputs flattened: 9 strobes, alu_op, alu_ctr, result, zero, taken, jr, illegal
  logic [50:0] obs;
  assign obs = {reg_dst, branch, mem_read, mem_write, byte_op, alu_src, reg_write, jump, move,
                alu_op, alu_ctr, alu_result, zero, branch_taken, jr, illegal};

  // Reference: instruction semantics computed directly from the mnemonic
  function automatic logic [50:0] model(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
    logic [5:0]  opc, fn;
    logic        rd, br, mr, mw, by, as, rw, jp, mv, ill, zr, tk, j_r;
    logic [2:0]  op, ctr;
    logic [31:0] res;
    opc = ins[31:26];
    fn  = ins[5:0];
    {rd, br, mr, mw, by, as, rw, jp, mv, ill} = '0;
    op  = 3'd0;
    ctr = 3'd0;
    res = 32'd0;
    case (opc)
      6'b000000: begin
        rd = 1; rw = 1; op = 3'b111;
        case (fn)
          6'b100000: begin ctr = 3'b101; res = a + b; end
          6'b100010: begin ctr = 3'b100; res = a - b; end
          6'b100100: begin ctr = 3'b001; res = a & b; end
          6'b100101: begin ctr = 3'b010; res = a | b; end
          6'b101010: begin ctr = 3'b110; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'b001000: begin ctr = 3'b000; res = 32'd0; end
          default:   begin ctr = 3'b000; res = 32'd0; ill = 1; end
        endcase
      end
      6'b001000: begin as = 1; rw = 1; op = 3'b101; res = a + imm; end
      6'b001001: begin as = 1; rw = 1; op = 3'b100; res = a - imm; end
      6'b001100: begin as = 1; rw = 1; op = 3'b001; res = a & imm; end
      6'b001101: begin as = 1; rw = 1; op = 3'b010; res = a | imm; end
      6'b001010: begin as = 1; rw = 1; op = 3'b110; res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
      6'b100011: begin as = 1; rw = 1; mr = 1; op = 3'b101; res = a + imm; end
      6'b100000: begin as = 1; rw = 1; mr = 1; by = 1; op = 3'b101; res = a + imm; end
      6'b101011: begin as = 1; mw = 1; op = 3'b101; res = a + imm; end
      6'b101000: begin as = 1; mw = 1; by = 1; op = 3'b101; res = a + imm; end
      6'b000100, 6'b100111: begin br = 1; op = 3'b100; res = a - b; end
      6'b000010: begin jp = 1; end
      6'b000011: begin jp = 1; rw = 1; end
      6'b010001: begin rd = 1; rw = 1; mv = 1; end
      default:   begin ill = 1; end
    endcase
    if (op != 3'b111) ctr = op;
    zr  = (res == 32'd0);
    tk  = br && ((opc == 6'b100111) ? !zr : zr);
    j_r = (ctr == 3'b000) && zr && !br;
    if (j_r) rw = 0;
    return {rd, br, mr, mw, by, as, rw, jp, mv, op, ctr, res, zr, tk, j_r, ill};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {opc, mid, fn};
  endfunction

  // Present one instruction on a falling edge and land just after the next rising edge
  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    @(negedge clock);
    instr   = i;
    src_a   = a;
    src_b   = b;
    imm_ext = im;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [50:0] exp;
    instr = mk(6'b000000, 6'b100000); src_a = 32'd3; src_b = 32'd4; imm_ext = 32'd9;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    logic [31:0] i;
    i = mk(6'b000000, 6'b100000);
    drive(i, 32'd7, 32'd5, 32'($urandom));
    checks++;
    if (obs !== model(i, 32'd7, 32'd5, imm_ext)) begin
      errors++;
      $display("FAIL add_model: got %h expected %h", obs, model(i, 32'd7, 32'd5, imm_ext));
    end
    checks++;
    if ({alu_ctr, alu_result, reg_dst, reg_write, zero} !== {3'b101, 32'd12, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_fields: ctr=%b res=%0d rd=%b rw=%b z=%b expected 101 12 1 1 0",
               alu_ctr, alu_result, reg_dst, reg_write, zero);
    end
  endtask

  task automatic test_bne;
    logic [31:0] i;
    i = mk(6'b100111, 6'($urandom));
    drive(i, 32'd9, 32'd9, 32'($urandom));
    checks++;
    if ({zero, branch, branch_taken} !== 3'b110) begin
      errors++;
      $display("FAIL bne_equal: z/br/tk=%b expected 110", {zero, branch, branch_taken});
    end
    drive(i, 32'd9, 32'd8, 32'($urandom));
    checks++;
    if ({zero, branch, branch_taken} !== 3'b011) begin
      errors++;
      $display("FAIL bne_differ: z/br/tk=%b expected 011", {zero, branch, branch_taken});
    end
    i = mk(6'b000100, 6'($urandom));
    drive(i, 32'd4, 32'd4, 32'($urandom));
    checks++;
    if (obs !== model(i, 32'd4, 32'd4, imm_ext)) begin
      errors++;
      $display("FAIL beq_model: got %h expected %h", obs, model(i, 32'd4, 32'd4, imm_ext));
    end
  endtask

  task automatic test_jr;
    logic [31:0] i;
    i = mk(6'b000000, 6'b001000);
    drive(i, 32'h1234, 32'h55, 32'($urandom));
    checks++;
    if ({alu_ctr, alu_result, jr, reg_write} !== {3'b000, 32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL jr_fields: ctr=%b res=%h jr=%b rw=%b expected 000 0 1 0",
               alu_ctr, alu_result, jr, reg_write);
    end
    i = mk(6'b000100, 6'b001000);
    drive(i, 32'h77, 32'h77, 32'($urandom));
    checks++;
    if ({jr, branch, branch_taken} !== 3'b011) begin
      errors++;
      $display("FAIL jr_beq: jr/br/tk=%b expected 011", {jr, branch, branch_taken});
    end
  endtask

  task automatic test_load;
    logic [31:0] i;
    i = mk(6'b100011, 6'($urandom));
    drive(i, 32'h100, 32'($urandom), 32'hFFFF_FFFC);
    checks++;
    if ({alu_result, mem_read, alu_src, byte_op} !== {32'hFC, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lw_fields: res=%h mr=%b as=%b by=%b expected fc 1 1 0",
               alu_result, mem_read, alu_src, byte_op);
    end
    i = mk(6'b100000, 6'($urandom));
    drive(i, 32'h100, 32'($urandom), 32'hFFFF_FFFC);
    checks++;
    if ({alu_result, mem_read, alu_src, byte_op} !== {32'hFC, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL lb_fields: res=%h mr=%b as=%b by=%b expected fc 1 1 1",
               alu_result, mem_read, alu_src, byte_op);
    end
  endtask

  task automatic test_slt_boundary;
    logic [31:0] i;
    i = mk(6'b001010, 6'($urandom));
    drive(i, 32'h8000_0000, 32'($urandom), 32'h7FFF_FFFF);
    checks++;
    if (alu_result !== 32'd1) begin
      errors++;
      $display("FAIL slti_min_lt_max: got %h expected 00000001", alu_result);
    end
    i = mk(6'b000000, 6'b101010);
    drive(i, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'($urandom));
    checks++;
    if ({alu_result, zero} !== {32'd0, 1'b1}) begin
      errors++;
      $display("FAIL slt_equal: res=%h z=%b expected 0 1", alu_result, zero);
    end
    i = mk(6'b000000, 6'b100010);
    drive(i, 32'd0, 32'd1, 32'($urandom));
    checks++;
    if (alu_result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sub_wrap: got %h expected ffffffff", alu_result);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  ops [15] = '{6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010,
                              6'b100011, 6'b100000, 6'b101011, 6'b101000, 6'b000100, 6'b100111,
                              6'b000010, 6'b000011, 6'b010001};
    logic [5:0]  fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
    logic [31:0] edge_vals [5] = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [5:0]  opc, fn;
    logic [31:0] i, a, b, im;
    for (int n = 0; n < 400; n++) begin
      opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 14)];
      fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      i   = mk(opc, fn);
      a   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      im  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 5) == 0) im = a;
      drive(i, a, b, im);
      checks++;
      if (obs !== model(i, a, b, im)) begin
        errors++;
        $display("FAIL random[%0d] instr=%h a=%h b=%h imm=%h: got %h expected %h",
                 n, i, a, b, im, obs, model(i, a, b, im));
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [31:0] i;
    logic [50:0] zero_v;
    zero_v = '0;
    i = mk(6'b000000, 6'b100000);
    drive(i, 32'd7, 32'd5, 32'd0);
    checks++;
    if (obs === zero_v) begin
      errors++;
      $display("FAIL pre_reset_nonzero: got %h expected nonzero", obs);
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== zero_v) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h expected 0", obs);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs !== zero_v) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", obs);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (obs !== model(i, 32'd7, 32'd5, 32'd0)) begin
      errors++;
      $display("FAIL post_release: got %h expected %h", obs, model(i, 32'd7, 32'd5, 32'd0));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bne();
    test_jr();
    test_load();
    test_slt_boundary();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
